// File: rtl/base_vmem_alloc.sv
// Entry allocator in front of a valid-bit memory: round-robin alloc grants, release forwarding,
// and a full-table flush sweep, tracked against a local shadow of the valid bits.
module base_vmem_alloc #(
  parameter int a_width   = 2,
  parameter int depth     = 1 << a_width,
  parameter int req_ports = 2,
  parameter int rel_ports = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [req_ports-1:0]             i_req_v,
  output logic [req_ports-1:0]             o_req_gnt,
  output logic [a_width-1:0]               o_req_a,
  output logic                             o_set_v,
  output logic [a_width-1:0]               o_set_a,
  input  logic [rel_ports-1:0]             i_rel_v,
  input  logic [rel_ports*a_width-1:0]     i_rel_a,
  output logic [rel_ports:0]               o_rst_v,
  output logic [(rel_ports+1)*a_width-1:0] o_rst_a,
  input  logic                             i_flush,
  output logic                             o_flush_busy,
  output logic [a_width:0]                 o_count,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int rr_w = (req_ports > 1) ? $clog2(req_ports) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [depth-1:0]     shadow, shadow_nxt, set_mask, clr_mask;
  logic [a_width-1:0]   sweep, sweep_nxt;
  logic                 drain_cnt, drain_nxt;
  logic [rr_w-1:0]      rr, cand, win;
  logic                 win_v;
  logic [a_width-1:0]   free_a;
  logic                 free_v;
  logic                 grant_go;
  logic [req_ports-1:0] gnt_nxt;
  logic [a_width:0]     cnt_nxt;

  // Round-robin: scan starting one past the last winner, wrapping.
  always_comb begin
    cand  = rr;
    win   = '0;
    win_v = 1'b0;
    for (int unsigned i = 0; i < req_ports; i++) begin
      cand = (cand == rr_w'(req_ports - 1)) ? '0 : cand + 1'b1;
      if (!win_v && i_req_v[cand]) begin
        win   = cand;
        win_v = 1'b1;
      end
    end
  end

  always_comb begin
    free_a = '0;
    free_v = 1'b0;
    for (int unsigned i = 0; i < depth; i++) begin
      if (!free_v && !shadow[i]) begin
        free_a = a_width'(i);
        free_v = 1'b1;
      end
    end
  end

  assign grant_go = (state == IDLE) && !i_flush && win_v && free_v;

  always_comb begin
    gnt_nxt = '0;
    if (grant_go) gnt_nxt[win] = 1'b1;
  end

  // Free search uses the pre-release shadow, so a set index is never also cleared this cycle.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant_go) set_mask[free_a] = 1'b1;
    for (int unsigned k = 0; k < rel_ports; k++) begin
      if (i_rel_v[k]) clr_mask[i_rel_a[k*a_width +: a_width]] = 1'b1;
    end
    if (state == FLUSH) clr_mask[sweep] = 1'b1;
    shadow_nxt = (shadow & ~clr_mask) | set_mask;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      cnt_nxt = cnt_nxt + (a_width+1)'(shadow_nxt[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (i_flush) begin
          state_nxt = FLUSH;
          sweep_nxt = '0;
        end
      end
      FLUSH: begin
        sweep_nxt = sweep + 1'b1;
        if (sweep == a_width'(depth - 1)) begin
          state_nxt = DRAIN;
          drain_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = IDLE;
        else           drain_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sweep     <= '0;
      drain_cnt <= 1'b0;
      shadow    <= '0;
      rr        <= rr_w'(req_ports - 1);
      o_req_gnt <= '0;
      o_req_a   <= '0;
      o_set_v   <= 1'b0;
      o_set_a   <= '0;
      o_rst_v   <= '0;
      o_rst_a   <= '0;
      o_count   <= '0;
    end else begin
      state     <= state_nxt;
      sweep     <= sweep_nxt;
      drain_cnt <= drain_nxt;
      shadow    <= shadow_nxt;
      if (grant_go) rr <= win;
      o_req_gnt <= gnt_nxt;
      o_req_a   <= grant_go ? free_a : '0;
      o_set_v   <= grant_go;
      o_set_a   <= grant_go ? free_a : '0;
      o_rst_v   <= {state == FLUSH, i_rel_v};
      o_rst_a   <= {sweep, i_rel_a};
      o_count   <= cnt_nxt;
    end
  end

  assign o_flush_busy = (state != IDLE);
  assign o_full       = (o_count == (a_width+1)'(depth));
  assign o_empty      = (o_count == '0);

endmodule
